// File: rtl/rr_arbiter8.sv
// rr_arbiter8 - round-robin arbiter sharing one resource among 8 requesters.
//
// A grant is held until its owner asserts done, drops its request, or has
// held it for MAX_HOLD cycles. At each release the next owner is searched
// starting just after the most recent winner, with the releasing requester
// masked for that edge. All outputs are registered.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   req[7:0]    request lines, bit i = requester i
//   done        current owner finished (only looked at while granted)
//   grant[7:0]  registered one-hot grant, zero when idle
//   grant_id    binary index of the grant bit, 0 when idle
//   grant_valid high while a grant is active
//   timeout     one-cycle pulse after a forced (hold-limit) release
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [2:0]       last, last_nx;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic [7:0]       grant_nx;
    logic [2:0]       grant_id_nx;
    logic             grant_valid_nx;
    logic             timeout_nx;

    logic [7:0] cand;
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    logic       owner_req;
    logic       at_limit;
    logic       release_now;

    always_comb begin
        owner_req   = req[grant_id];
        at_limit    = (hold_cnt == HOLD_LAST);
        release_now = done || !owner_req || at_limit;
    end

    // While granted, the current owner is excluded so a release is always
    // visible even when it is the only requester left.
    always_comb begin
        cand = (state == GRANT) ? (req & ~grant) : req;
    end

    // Priority search starting at last+1 and wrapping; offset 8 lands on last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        last_nx        = last;
        hold_cnt_nx    = hold_cnt;
        grant_nx       = grant;
        grant_id_nx    = grant_id;
        grant_valid_nx = grant_valid;
        timeout_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nx       = GRANT;
                    grant_nx       = 8'(1) << win;
                    grant_id_nx    = win;
                    grant_valid_nx = 1'b1;
                    last_nx        = win;
                    hold_cnt_nx    = '0;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end else begin
                    // Only a pure hold-limit release is reported as timeout.
                    timeout_nx  = at_limit && !done && owner_req;
                    hold_cnt_nx = '0;
                    if (found) begin
                        grant_nx       = 8'(1) << win;
                        grant_id_nx    = win;
                        grant_valid_nx = 1'b1;
                        last_nx        = win;
                    end else begin
                        state_nx       = IDLE;
                        grant_nx       = '0;
                        grant_id_nx    = '0;
                        grant_valid_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 3'd7;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nx;
            last        <= last_nx;
            hold_cnt    <= hold_cnt_nx;
            grant       <= grant_nx;
            grant_id    <= grant_id_nx;
            grant_valid <= grant_valid_nx;
            timeout     <= timeout_nx;
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant));
    a_valid_matches : assert property (@(posedge clk) disable iff (rst)
        grant_valid == (|grant));
    a_id_matches : assert property (@(posedge clk) disable iff (rst)
        grant == (grant_valid ? (8'(1) << grant_id) : 8'h00));
    a_hold_bound : assert property (@(posedge clk) disable iff (rst)
        (state == GRANT) |-> (hold_cnt <= HOLD_LAST));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8 (MAX_HOLD overridden to 4). Directed stimulus
// pushes the expected outputs for the following cycle into a queue; a
// separate monitor pops and compares them on the falling clock edge.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  g;
        logic [2:0]  id;
        logic        v;
        logic        to;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    event        async_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    task automatic push(input int unsigned at, input logic [7:0] g, input logic [2:0] id,
                        input logic to, input string nm);
        exp_t e;
        e.cyc  = at;
        e.g    = g;
        e.id   = id;
        e.v    = (g != 8'h00);
        e.to   = to;
        e.name = nm;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs; expected outputs appear after the next edge.
    task automatic step(input logic [7:0] r, input logic d, input logic [7:0] g,
                        input logic [2:0] id, input logic to, input string nm);
        req  = r;
        done = d;
        push(cyc + 1, g, id, to, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = 8'h00;
        done = 1'b0;
        rst  = 1'b1;
        push(cyc + 1, 8'h00, 3'd0, 1'b0, "reset_pulse");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or async_ev);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc || grant !== e.g || grant_id !== e.id ||
                    grant_valid !== e.v || timeout !== e.to) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got grant=%h id=%0d valid=%b timeout=%b, expected grant=%h id=%0d valid=%b timeout=%b (for cyc %0d)",
                             e.name, cyc, grant, grant_id, grant_valid, timeout,
                             e.g, e.id, e.v, e.to, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        @(posedge clk);
        #1;
        push(cyc, 8'h00, 3'd0, 1'b0, "reset");
        rst = 1'b0;

        repeat (5) step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "idle");

        step(8'h24, 1'b0, 8'h04, 3'd2, 1'b0, "first_grant");
        step(8'h24, 1'b1, 8'h20, 3'd5, 1'b0, "b2b_grant");
        step(8'h24, 1'b1, 8'h04, 3'd2, 1'b0, "wrap_back");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "release_idle");

        do_reset();
        for (int i = 0; i < 10; i++)
            step(8'hFF, 1'b1, 8'(1) << (i % 8), 3'(i % 8), 1'b0, "rotate");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "rotate_end");

        step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0, "hold_start");
        repeat (3) step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0, "hold");
        step(8'h08, 1'b0, 8'h00, 3'd0, 1'b1, "timeout_idle");
        step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0, "regrant");
        repeat (3) step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0, "hold2");
        step(8'h08, 1'b1, 8'h00, 3'd0, 1'b0, "done_at_limit");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "idle_after");

        step(8'h43, 1'b0, 8'h40, 3'd6, 1'b0, "grant6");
        step(8'h03, 1'b0, 8'h01, 3'd0, 1'b0, "wrap_to0");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "idle3");

        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0, "grant4");
        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0, "grant4_hold");

        // Reset in the middle of a cycle, well away from any clock edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        push(cyc, 8'h00, 3'd0, 1'b0, "async_reset");
        ->async_ev;
        push(cyc + 1, 8'h00, 3'd0, 1'b0, "reset_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h90, 1'b0, 8'h10, 3'd4, 1'b0, "post_reset");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "final_idle");

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
